// File: rtl/fp_instr_encoder_pkg.sv
// Shared F-extension encoding definitions: op codes, func7/rm constants and the
// combinational word packer used by this encoder and the matching decoder.
package fp_instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SQRT = 4'd4,
    OP_MAX  = 4'd5,
    OP_MIN  = 4'd6,
    OP_EQ   = 4'd7,
    OP_LT   = 4'd8,
    OP_LE   = 4'd9
  } op_sel_e;

  localparam logic [6:0] OPCODE_FP = 7'b1010011;

  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0000100;
  localparam logic [6:0] F7_MUL    = 7'b0001000;
  localparam logic [6:0] F7_DIV    = 7'b0001100;
  localparam logic [6:0] F7_SQRT   = 7'b0101100;
  localparam logic [6:0] F7_MINMAX = 7'b0010100;
  localparam logic [6:0] F7_CMP    = 7'b1010000;

  localparam logic [2:0] RM_SQRT = 3'b000;
  localparam logic [2:0] RM_MAX  = 3'b001;
  localparam logic [2:0] RM_MIN  = 3'b000;
  localparam logic [2:0] RM_EQ   = 3'b010;
  localparam logic [2:0] RM_LT   = 3'b001;
  localparam logic [2:0] RM_LE   = 3'b000;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_LE;
  endfunction

  // Only the arithmetic ops carry the caller's rounding mode; the rest use the
  // rm slot as a sub-function selector.
  function automatic logic [31:0] fp_instr_pack(
    input logic [3:0] op,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [4:0] rd,
    input logic [2:0] rm
  );
    logic [6:0] f7;
    logic [2:0] rm_f;
    logic [4:0] rs2_f;
    f7    = F7_ADD;
    rm_f  = rm;
    rs2_f = rs2;
    case (op)
      OP_ADD:  f7 = F7_ADD;
      OP_SUB:  f7 = F7_SUB;
      OP_MUL:  f7 = F7_MUL;
      OP_DIV:  f7 = F7_DIV;
      OP_SQRT: begin f7 = F7_SQRT;   rm_f = RM_SQRT; rs2_f = 5'd0; end
      OP_MAX:  begin f7 = F7_MINMAX; rm_f = RM_MAX; end
      OP_MIN:  begin f7 = F7_MINMAX; rm_f = RM_MIN; end
      OP_EQ:   begin f7 = F7_CMP;    rm_f = RM_EQ;  end
      OP_LT:   begin f7 = F7_CMP;    rm_f = RM_LT;  end
      OP_LE:   begin f7 = F7_CMP;    rm_f = RM_LE;  end
      default: begin f7 = F7_ADD;    rm_f = 3'b000; rs2_f = 5'd0; end
    endcase
    return {f7, rs2_f, rs1, rm_f, rd, OPCODE_FP};
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO whose head entry is presented straight from the storage
// registers; occupancy counter doubles as full/empty source.
module fp_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers are exactly AW bits wide, so wrapping modulo DEPTH is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fp_instr_encoder.sv
// Accepts FP operation requests, packs them into RISC-V F-extension words and
// queues them for a downstream consumer with valid/ready handshaking.
module fp_instr_encoder
  import fp_instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [3:0]             op_sel,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rd,
  input  logic [2:0]             rm,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [31:0]            instr,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            issue_cnt
);

  logic        r_started;
  logic        r_illegal;
  logic [15:0] r_issue_cnt;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_legal;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  // Ready depends only on registered state, so a same-cycle pop never frees a slot.
  assign op_ready    = r_started && !w_full;
  assign w_accept    = op_valid && op_ready;
  assign w_legal     = op_is_legal(op_sel);
  assign w_push      = w_accept && w_legal;
  assign instr_valid = !w_empty;
  assign w_pop       = instr_valid && instr_ready;
  assign w_word      = fp_instr_pack(op_sel, rs1, rs2, rd, rm);
  assign illegal     = r_illegal;
  assign issue_cnt   = r_issue_cnt;

  fp_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (instr),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_started   <= 1'b0;
      r_illegal   <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      r_started <= 1'b1;
      r_illegal <= w_accept && !w_legal;
      if (w_pop) r_issue_cnt <= r_issue_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_instr_encoder.sv
// Self-checking bench for fp_instr_encoder: fixed encoding vectors, handshake
// corner sequences and a randomized run against a queue-based reference model.
module tb_fp_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        opValid;
  logic        opReady;
  logic [3:0]  opSel;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  rm;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic        illegal;
  logic [2:0]  level;
  logic [15:0] issueCnt;

  always #5 clk = ~clk;

  fp_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (opValid),
    .op_ready    (opReady),
    .op_sel      (opSel),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .rm          (rm),
    .instr_valid (instrValid),
    .instr_ready (instrReady),
    .instr       (instr),
    .illegal     (illegal),
    .level       (level),
    .issue_cnt   (issueCnt)
  );

  typedef struct {
    int          op;
    int          a;
    int          b;
    int          d;
    int          r;
    logic [31:0] expWord;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] mq[$];
  int          mIssue;
  bit          mStarted;
  bit          mIllegal;
  int          nChecks = 0;
  int          nFails  = 0;

  // Reference encoder built from field weights rather than bit concatenation.
  function automatic logic [31:0] refEncode(int op, int a, int b, int d, int r);
    longint f7, rmf, b2;
    b2 = b; rmf = r; f7 = 0;
    case (op)
      0: f7 = 0;
      1: f7 = 4;
      2: f7 = 8;
      3: f7 = 12;
      4: begin f7 = 44; rmf = 0; b2 = 0; end
      5: begin f7 = 20; rmf = 1; end
      6: begin f7 = 20; rmf = 0; end
      7: begin f7 = 80; rmf = 2; end
      8: begin f7 = 80; rmf = 1; end
      9: begin f7 = 80; rmf = 0; end
      default: f7 = 0;
    endcase
    return 32'(f7 * 64'd33554432 + b2 * 64'd1048576 + longint'(a) * 64'd32768
               + rmf * 64'd4096 + longint'(d) * 64'd128 + 64'd83);
  endfunction

  task automatic modelReset();
    mq.delete();
    mIssue   = 0;
    mStarted = 0;
    mIllegal = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".op_ready"}, 32'(opReady), 32'(mStarted && mq.size() < DEPTH));
    checkOutput({tag, ".instr_valid"}, 32'(instrValid), 32'(mq.size() != 0));
    checkOutput({tag, ".level"}, 32'(level), 32'(mq.size()));
    checkOutput({tag, ".illegal"}, 32'(illegal), 32'(mIllegal));
    checkOutput({tag, ".issue_cnt"}, 32'(issueCnt), 32'(mIssue));
    if (mq.size() != 0) checkOutput({tag, ".instr"}, instr, mq[0]);
  endtask

  // One clock cycle: drive at the falling edge, advance the model, check #1 after the rising edge.
  task automatic applyStimulus(input string tag, input bit v, input int sel, input int a,
                               input int b, input int d, input int r, input bit rdy);
    bit accept, pop;
    @(negedge clk);
    opValid    = v;
    opSel      = 4'(sel);
    rs1        = 5'(a);
    rs2        = 5'(b);
    rd         = 5'(d);
    rm         = 3'(r);
    instrReady = rdy;
    accept = v && mStarted && (mq.size() < DEPTH);
    pop    = rdy && (mq.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      mIssue = (mIssue + 1) % 65536;
    end
    if (accept && sel < 10) mq.push_back(refEncode(sel, a, b, d, r));
    mIllegal = accept && (sel >= 10);
    mStarted = 1;
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    applyStimulus(tag, 1'b0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    idle("restart", 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, 1, 2, 3, 0, 32'h002081D3};
    vecs[1] = '{4, 5, 7, 6, 7, 32'h58028353};
    vecs[2] = '{5, 1, 2, 3, 7, 32'h282091D3};
    vecs[3] = '{7, 1, 2, 3, 0, 32'hA020A1D3};
    vecs[4] = '{1, 1, 2, 3, 2, 32'h0820A1D3};
    vecs[5] = '{2, 10, 11, 12, 1, 32'h10B51653};
    vecs[6] = '{3, 31, 31, 31, 7, 32'h19FFFFD3};
    vecs[7] = '{6, 1, 2, 3, 5, 32'h282081D3};
    vecs[8] = '{8, 1, 2, 3, 0, 32'hA02091D3};
    vecs[9] = '{9, 1, 2, 3, 6, 32'hA02081D3};

    rst = 1'b0; opValid = 1'b0; opSel = '0; rs1 = '0; rs2 = '0; rd = '0; rm = '0;
    instrReady = 1'b0;
    modelReset();

    // Reset state, held across clock edges
    #22;
    checkAll("reset");
    checkOutput("reset.instr", instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("pre_first_edge.op_ready", 32'(opReady), 32'h0);
    idle("first_edge", 1'b0);

    // Encoding table: each op into an empty FIFO, visible one cycle later
    for (int i = 0; i < 10; i++) begin
      applyStimulus("vec_push", 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].r, 1'b0);
      checkOutput($sformatf("vec%0d.word", i), instr, vecs[i].expWord);
      checkOutput($sformatf("vec%0d.valid", i), 32'(instrValid), 32'h1);
      idle("vec_pop", 1'b1);
    end

    // Fill with consumer stalled, fifth op refused, then drain in order
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus("fill", 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].r, 1'b0);
      if (i == 3) begin
        checkOutput("fill.level4", 32'(level), 32'd4);
        checkOutput("fill.not_ready", 32'(opReady), 32'h0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d.word", i), instr, vecs[i].expWord);
      idle("drain", 1'b1);
    end
    checkOutput("drain.issue_cnt", 32'(issueCnt), 32'd4);
    checkOutput("drain.empty", 32'(instrValid), 32'h0);

    // Illegal op: one-cycle pulse, FIFO untouched
    applyStimulus("ill_pre", 1'b1, 2, 3, 4, 5, 1, 1'b0);
    applyStimulus("ill_op", 1'b1, 12, 3, 4, 5, 1, 1'b0);
    checkOutput("ill.pulse", 32'(illegal), 32'h1);
    checkOutput("ill.level", 32'(level), 32'd1);
    idle("ill_after", 1'b0);
    checkOutput("ill.pulse_end", 32'(illegal), 32'h0);

    // Simultaneous push and pop at partial occupancy
    applyStimulus("sim_fill", 1'b1, 6, 7, 8, 9, 0, 1'b0);
    applyStimulus("sim_pushpop", 1'b1, 8, 1, 1, 1, 0, 1'b1);
    checkOutput("sim.level", 32'(level), 32'd2);
    idle("sim_drain", 1'b1);
    idle("sim_drain", 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", ($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 5));
    end

    // Asynchronous reset with queued words
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus("async_fill", 1'b1, i, i + 1, i + 2, i + 3, 0, 1'b0);
    checkOutput("async.level3", 32'(level), 32'd3);
    @(negedge clk);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async.level", 32'(level), 32'h0);
    checkOutput("async.valid", 32'(instrValid), 32'h0);
    checkOutput("async.op_ready", 32'(opReady), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle("async_restart", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
